// File: rtl/axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_bridge
// Description : Single-outstanding AXI4 master; read bursts and single-beat
//               writes from a simple request port, unified response port.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_master_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        aclk,
    input  logic        aresetn,
    // core request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_len,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    // core response port
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_last,
    output logic        resp_err,
    // AXI read address
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    // AXI write data
    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    localparam logic [1:0] c_burst_incr = 2'b01;

    state_t      r_state;
    logic        r_req_ready;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_len;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [7:0]  r_beat_cnt;
    logic        r_arvalid;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_aw_done;
    logic        r_w_done;

    logic w_r_hs;
    logic w_b_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;

    assign w_r_hs        = (r_state == S_R) && rvalid && resp_ready;
    assign w_b_hs        = (r_state == S_B) && bvalid && resp_ready;
    assign w_aw_hs       = r_awvalid && awready;
    assign w_w_hs        = r_wvalid && wready;
    assign w_aw_done_nxt = r_aw_done || w_aw_hs;
    assign w_w_done_nxt  = r_w_done || w_w_hs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_len       <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_beat_cnt  <= '0;
            r_arvalid   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_len       <= req_len;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        r_beat_cnt  <= '0;
                        if (req_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_AW_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (w_r_hs) begin
                        // Saturate so overlong bursts keep being flagged.
                        if (r_beat_cnt != 8'hFF) begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                        if (rlast) begin
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_b_hs) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;

    assign araddr  = r_addr;
    assign arid    = AXI_ID;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = c_burst_incr;
    assign arvalid = r_arvalid;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign awaddr  = r_addr;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awsize  = r_size;
    assign awburst = c_burst_incr;
    assign awvalid = r_awvalid;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid    = AXI_ID;
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;
    assign wlast  = 1'b1;
    assign wvalid = r_wvalid;

    assign rready = (r_state == S_R) && resp_ready;
    assign bready = (r_state == S_B) && resp_ready;

    // Responses are pure pass-through from R or B; nothing is buffered.
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = rdata;
        resp_last  = 1'b0;
        resp_err   = 1'b0;
        if (r_state == S_R) begin
            resp_valid = rvalid;
            resp_last  = rlast;
            resp_err   = (rresp != 2'b00) || (rid != AXI_ID)
                       || (rlast && (r_beat_cnt != r_len));
        end else if (r_state == S_B) begin
            resp_valid = bvalid;
            resp_last  = 1'b1;
            resp_err   = (bresp != 2'b00) || (bid != AXI_ID);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_master_bridge
// Description : Randomized scoreboard bench; the bench plays the AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_master_bridge;

    localparam logic [3:0] c_id = 4'd5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [7:0]  req_len = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_last, resp_err;
    logic [63:0] resp_rdata;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, awid, wid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache;
    logic        arvalid, arready = 1'b0, awvalid, awready = 1'b0;
    logic [3:0]  rid = '0, bid = '0;
    logic [63:0] rdata = '0, wdata;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic        wlast, wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;

    axi_master_bridge #(.AXI_ID(c_id)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_last(resp_last), .resp_err(resp_err),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_wr;
        logic [63:0] data;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic rr_pat[$];
    int   checks = 0;
    int   failures = 0;
    bool_t_dummy_unused_never u_never();

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // resp_ready: scripted pattern when queued, otherwise random (mostly high)
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rr_pat.size() > 0) resp_ready = rr_pat.pop_front();
            else resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every response handshake is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (!e.is_wr) check("resp_rdata", resp_rdata, e.data);
                    check("resp_last", {63'd0, resp_last}, {63'd0, e.last});
                    check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [7:0] len, input logic [63:0] wd, input logic [7:0] ws);
        logic ok;
        int   n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
        req_len = len; req_wdata = wd; req_wstrb = ws;
        n = 0;
        do begin
            @(negedge aclk);
            ok = req_ready;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    // Slave side of one read. Expected responses derive from the rules:
    // error on bad rresp/rid, and on the rlast beat if its index != len.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int nbeats, input int ard, input int bad_resp, input int bad_id);
        logic [63:0] d[$];
        exp_t e;
        int   idx, n;
        logic hs;
        issue(1'b0, addr, size, len, 64'd0, 8'd0);
        check("arvalid_on", {63'd0, arvalid}, 64'd1);
        for (int c = 0; c <= ard; c++) begin
            check("araddr", {32'd0, araddr}, {32'd0, addr});
            check("arlen", {56'd0, arlen}, {56'd0, len});
            check("arsize", {61'd0, arsize}, {61'd0, size});
            check("arburst", {62'd0, arburst}, 64'd1);
            arready = (c == ard);
            tick();
        end
        arready = 1'b0;
        check("arvalid_off", {63'd0, arvalid}, 64'd0);
        for (int i = 0; i < nbeats; i++) begin
            d.push_back({$urandom, $urandom});
            idx = (i > 255) ? 255 : i;
            e.is_wr = 1'b0;
            e.data  = d[i];
            e.last  = (i == nbeats - 1);
            e.err   = (i == bad_resp) || (i == bad_id) || (e.last && idx != int'(len));
            sb.push_back(e);
        end
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1'b1; rdata = d[i]; rlast = (i == nbeats - 1);
            rresp = (i == bad_resp) ? 2'd2 : 2'd0;
            rid = (i == bad_id) ? ~c_id : c_id;
            hs = 1'b0; n = 0;
            while (!hs && n < 100) begin
                @(negedge aclk);
                check("rready_mirror", {63'd0, rready}, {63'd0, resp_ready});
                hs = rready;
                tick();
                n++;
            end
            if (!hs) check("r_timeout", 64'd0, 64'd1);
            rvalid = 1'b0;
            if ($urandom_range(0, 3) == 0 && i != nbeats - 1) tick();
        end
        rlast = 1'b0;
        check("req_ready_after_r", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws,
                            input int awd, input int wdl, input logic [1:0] br, input logic [3:0] bi);
        exp_t e;
        int   n;
        logic hs;
        issue(1'b1, addr, 3'd3, 8'd7, wd, ws);
        check("awvalid_on", {63'd0, awvalid}, 64'd1);
        check("wvalid_on", {63'd0, wvalid}, 64'd1);
        check("awaddr", {32'd0, awaddr}, {32'd0, addr});
        check("awlen", {56'd0, awlen}, 64'd0);
        check("awburst", {62'd0, awburst}, 64'd1);
        check("wdata", wdata, wd);
        check("wstrb", {56'd0, wstrb}, {56'd0, ws});
        check("wlast", {63'd0, wlast}, 64'd1);
        e.is_wr = 1'b1; e.data = '0; e.last = 1'b1;
        e.err = (br != 2'd0) || (bi != c_id);
        sb.push_back(e);
        for (int c = 0; c <= ((awd > wdl) ? awd : wdl); c++) begin
            awready = (c == awd);
            wready  = (c == wdl);
            tick();
            check("awvalid_hold", {63'd0, awvalid}, {63'd0, c < awd});
            check("wvalid_hold", {63'd0, wvalid}, {63'd0, c < wdl});
        end
        awready = 1'b0; wready = 1'b0;
        if ($urandom_range(0, 1) == 1) tick();
        bvalid = 1'b1; bresp = br; bid = bi;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge aclk);
            hs = bready;
            tick();
            n++;
        end
        if (!hs) check("b_timeout", 64'd0, 64'd1);
        bvalid = 1'b0;
        check("req_ready_after_b", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int len, nb;
        repeat (3) tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_valids", {60'd0, arvalid, awvalid, wvalid, resp_valid}, 64'd0);
        check("rst_readies", {62'd0, rready, bready}, 64'd0);
        aresetn = 1'b1;
        tick();
        check("req_ready_after_rst", {63'd0, req_ready}, 64'd1);

        do_read(32'h8000_0000, 8'd0, 3'd2, 1, 0, -1, -1);
        do_read(32'h8000_0040, 8'd3, 3'd3, 4, 3, -1, -1);
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_read(32'h8000_0080, 8'd3, 3'd3, 4, 0, -1, -1);
        do_write(32'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 1, 0, 2'd0, c_id);
        do_write(32'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 1, 0, 2'd2, c_id);
        do_write(32'h8000_1008, 64'h1234, 8'hFF, 0, 2, 2'd0, c_id);
        do_write(32'h8000_1010, 64'h5678, 8'hF0, 1, 1, 2'd0, ~c_id);
        do_read(32'h8000_0100, 8'd3, 3'd3, 2, 0, -1, -1);
        do_read(32'h8000_0140, 8'd3, 3'd3, 4, 1, 1, -1);
        do_read(32'h8000_0180, 8'd1, 3'd3, 4, 0, -1, 0);

        // Reset asserted while AR is pending.
        issue(1'b0, 32'h8000_0200, 3'd3, 8'd0, 64'd0, 8'd0);
        tick();
        check("ar_pending", {63'd0, arvalid}, 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check("rst_async_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst_async_req_ready", {63'd0, req_ready}, 64'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check("req_ready_after_rst2", {63'd0, req_ready}, 64'd1);
        do_read(32'h8000_0000, 8'd0, 3'd3, 1, 1, -1, -1);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(0, 4);
                nb = len + 1;
                if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, len + 3);
                do_read($urandom & 32'hFFFF_FFF8, 8'(len), 3'($urandom_range(0, 3)), nb,
                        $urandom_range(0, 3),
                        ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1,
                        ($urandom_range(0, 6) == 0) ? $urandom_range(0, nb - 1) : -1);
            end else begin
                do_write($urandom, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), 2'($urandom_range(0, 3) == 0 ? 2 : 0),
                         ($urandom_range(0, 6) == 0) ? ~c_id : c_id);
            end
        end

        repeat (3) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

module bool_t_dummy_unused_never;
endmodule
`default_nettype wire

// File: doc/axi_master_bridge.md
# axi_master_bridge

AXI4 master that turns the core's simple single-request memory port (instruction fetch / LSU / cache refill) into AXI4 read bursts and single-beat writes toward the `sim_sram` slave model or any AXI4 slave. It holds one outstanding transaction at a time and returns read beats and write completions on a unified response port. It is the initiator end of the 64-bit AXI4 interface that `sim_sram` answers.

## Interface

Parameters:
- `AXI_ID`, default 0: value driven on `arid`, `awid` and `wid`; expected on `rid` and `bid`.

Ports (one clock; reset is asynchronous and active-low):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `req_valid` / `req_ready` in / out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_size` in 3: AXI size code (0 to 3); driven on `arsize` / `awsize`.
- `req_len` in 8: read burst beats minus 1. Ignored for writes.
- `req_wdata` / `req_wstrb` in 64 / 8: write data and byte strobes.
- `resp_valid` / `resp_ready` out / in 1: response handshake.
- `resp_rdata` out 64: read beat data. Undefined for writes.
- `resp_last` out 1: final response of the transaction.
- `resp_err` out 1: error flag for this response.
- `araddr/arid/arlen/arsize/arburst/arvalid` out 32/4/8/3/2/1; `arready` in 1.
- `rid/rdata/rresp/rlast/rvalid` in 4/64/2/1/1; `rready` out 1.
- `awaddr/awid/awlen/awsize/awburst/awvalid` out 32/4/8/3/2/1; `awready` in 1.
- `wid/wdata/wstrb/wlast/wvalid` out 4/64/8/1/1; `wready` in 1.
- `bid/bresp/bvalid` in 4/2/1; `bready` out 1.
- `arlock/arcache/arprot`, `awlock/awcache/awprot` out 2/4/3 each: constant 0.

## Operation

- States: IDLE, AR, R, AW_W, B.
- IDLE: `req_ready`=1. On `req_valid`, latch addr, size, len, wdata, wstrb and clear the beat counter. Go to AR if reading, AW_W if writing.
- AR: `arvalid`=1 with the latched fields, `arburst`=2'b01 (INCR). Fields stay stable until `arready`; then go to R.
- R: `rready` = `resp_ready`. Response outputs pass straight through: `resp_valid` = `rvalid`, `resp_rdata` = `rdata`, `resp_last` = `rlast`. Each handshake increments the 8-bit beat counter.
  - `resp_err` = (`rresp` != 0) | (`rid` != `AXI_ID`). On the `rlast` beat it also includes (beat count != latched len).
  - The transaction ends only on `rlast`. Extra beats beyond len are forwarded and flagged; the counter saturates at 255.
- AW_W: `awvalid` and `wvalid` both assert on entry. `awlen`=0, `awburst`=INCR, `wlast`=1. Each valid drops independently after its own handshake; accepted-flags track which are done. W may complete before, with, or after AW. Go to B once both are done.
- B: `bready` = `resp_ready`; `resp_valid` = `bvalid`, `resp_last`=1, `resp_err` = (`bresp` != 0) | (`bid` != `AXI_ID`). On handshake go to IDLE.
- `req_ready`=0 in every state except IDLE; no new request is accepted until the current one completes.

## Timing

- Reset values: state IDLE, `req_ready`=0 while `aresetn`=0 and 1 from the first clock after release. All AXI valids and readies are 0, `resp_valid`=0, counters and flags are 0.
- Reset asserted mid-transaction: all of the above take effect immediately (asynchronous) and the transaction is abandoned.
- Request accepted at cycle N: `arvalid` (or `awvalid` + `wvalid`) is high at N+1 from registers.
- Read latency is zero-cycle pass-through from the R channel to the response port. With `arready` at N+1, the first beat can be delivered at N+2 at the earliest.
- Last R or B handshake at cycle M: IDLE and `req_ready`=1 at M+1. Back-to-back requests are therefore spaced at least 3 cycles apart.
- `resp_ready`=0 stalls R and B, and AXI valids must hold. The bridge adds no buffering.

## Test plan

- Single read, len=0, addr 0x80000000, slave returns 0x00000013 with rlast and OKAY: exactly one response with rdata 0x13, last=1, err=0; `req_ready` back high 1 cycle later.
- Burst read, len=3, size=3, slave returns 4 beats with rlast on beat 4: four responses in order; `resp_last` only on the 4th; `araddr`, `arlen`=3 and `arsize`=3 held stable until `arready`.
- Read with `resp_ready` toggling 1,0,0,1 during the burst: `rready` mirrors `resp_ready`; no beat is lost or duplicated.
- Write 0xDEADBEEF, strb 0x0F to 0x80001000:
  - Case 1: `wready` one cycle before `awready`, then OKAY response. Required: `wvalid` drops after its handshake and `awvalid` holds; one response with last=1, err=0.
  - Case 2: same write with `bresp`=SLVERR. Required: `resp_err`=1.
- Read with len=3 but slave asserts rlast on beat 2, and a separate beat with rresp=2: last response flagged err=1; bridge returns to IDLE.
- `aresetn` pulled low during AR: `arvalid`=0 immediately; after release, a fresh read completes correctly.
